led_pulse_stretcher: RTL and testbench

// - Output-side counterpart of the pushbutton debouncer: turns one-cycle internal events
//   (e.g. a debounced press strobe) into clean, human-visible LED blinks.
// - Each event produces exactly one blink: ON_CYCLES high, then OFF_CYCLES forced low.
// - Events arriving during a blink are queued (saturating counter), so none merge or vanish silently.
// - Sits between control logic and a board LED/buzzer pin.

---
 rtl/led_pulse_stretcher.sv | 150 +++++++++++++++
 tb/tb_led_pulse_stretcher.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/led_pulse_stretcher.sv
// ----------------------------------------------------------------------------
// led_pulse_stretcher
//
// Turns one-cycle internal events into human-visible blinks: each accepted
// event produces ON_CYCLES of led high followed by OFF_CYCLES of forced low.
// Events that arrive while a blink is in progress are counted in a saturating
// pending counter and replayed back-to-back.
//
// Ports
//   clk_i       rising-edge clock
//   rst_i       asynchronous reset, active high
//   ev_i        event strobe; every sampled high cycle is one event
//   led_o       stretched LED drive (registered)
//   busy_o      high while a blink (on or gap phase) is in progress (registered)
//   pending_o   queued events not yet started (registered)
//   overflow_o  one-cycle pulse: an event was dropped because the queue was full
// ----------------------------------------------------------------------------
module led_pulse_stretcher #(
    parameter int unsigned ON_CYCLES  = 500000,
    parameter int unsigned OFF_CYCLES = 500000,
    parameter int unsigned CNT_W      = 19,
    parameter int unsigned PEND_W     = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ev_i,
    output logic              led_o,
    output logic              busy_o,
    output logic [PEND_W-1:0] pending_o,
    output logic              overflow_o
);

    // Durations must fit the shared counter; reject bad configurations at elaboration.
    if (CNT_W < 1 || CNT_W > 31) begin : gen_bad_cnt_w
        $error("led_pulse_stretcher: CNT_W must be in 1..31");
    end
    if (PEND_W < 1 || PEND_W > 31) begin : gen_bad_pend_w
        $error("led_pulse_stretcher: PEND_W must be in 1..31");
    end
    if (ON_CYCLES < 1 || ON_CYCLES > (2 ** CNT_W) - 1) begin : gen_bad_on
        $error("led_pulse_stretcher: ON_CYCLES out of range 1..2^CNT_W-1");
    end
    if (OFF_CYCLES < 1 || OFF_CYCLES > (2 ** CNT_W) - 1) begin : gen_bad_off
        $error("led_pulse_stretcher: OFF_CYCLES out of range 1..2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0]  OnLast  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  OffLast = CNT_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PendMax = '1;

    typedef enum logic [1:0] {
        StIdle,
        StOn,
        StGap
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              led_q, led_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;

    logic on_done;
    logic gap_done;
    logic can_start;
    logic start;
    logic take_queued;
    logic want_inc;
    logic drop;

    always_comb begin
        on_done   = (state_q == StOn) && (cnt_q == OnLast);
        gap_done  = (state_q == StGap) && (cnt_q == OffLast);
        can_start = (state_q == StIdle) || gap_done;
        start     = can_start && (ev_i || (pend_q != '0));
        // A start always drains the queue first; the event itself is only
        // consumed directly when nothing is waiting ahead of it.
        take_queued = start && (pend_q != '0);
        want_inc    = ev_i && !(start && !take_queued);
        // A same-edge consumption frees a slot, so a full queue accepts the event.
        drop        = want_inc && (pend_q == PendMax) && !take_queued;

        pend_d = pend_q;
        if (want_inc && !take_queued && !drop) begin
            pend_d = pend_q + PEND_W'(1);
        end else if (!want_inc && take_queued) begin
            pend_d = pend_q - PEND_W'(1);
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start) begin
                    state_d = StOn;
                end
            end
            StOn: begin
                if (on_done) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StGap: begin
                if (gap_done) begin
                    state_d = start ? StOn : StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        led_d  = (state_d == StOn);
        busy_d = (state_d != StIdle);
        ovf_d  = drop;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign led_o      = led_q;
    assign busy_o     = busy_q;
    assign pending_o  = pend_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// ----------------------------------------------------------------------------
// tb_led_pulse_stretcher
//
// Directed and random event streams against a reference model that tracks
// the blink as "cycles left in the current blink" plus an integer queue.
// ----------------------------------------------------------------------------
module tb_led_pulse_stretcher;

    localparam int unsigned OnC   = 4;
    localparam int unsigned OffC  = 3;
    localparam int unsigned CntW  = 4;
    localparam int unsigned PendW = 3;
    localparam int PendMax = 7;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             ev_i;
    logic             led_o;
    logic             busy_o;
    logic [PendW-1:0] pending_o;
    logic             overflow_o;

    led_pulse_stretcher #(
        .ON_CYCLES (OnC),
        .OFF_CYCLES(OffC),
        .CNT_W     (CntW),
        .PEND_W    (PendW)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ev_i      (ev_i),
        .led_o     (led_o),
        .busy_o    (busy_o),
        .pending_o (pending_o),
        .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    int stepn    = 0;

    // Reference model state
    int m_pend   = 0;
    int m_left   = 0;  // cycles remaining in current blink (0 = idle)
    bit m_ovf    = 0;
    int m_blinks = 0;
    int m_ovfs   = 0;

    // Observed DUT activity
    int   dut_blinks = 0;
    int   dut_ovfs   = 0;
    logic prev_led   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s step=%0d got=%0d exp=%0d", tag, stepn, got, exp);
        end
    endtask

    task automatic model_edge(input bit v);
        if (m_left <= 1 && (v || m_pend > 0)) begin
            if (m_pend > 0) begin
                m_pend--;
                if (v) m_pend++;
            end
            m_left = OnC + OffC;
            m_ovf  = 0;
            m_blinks++;
        end else begin
            if (m_left > 0) m_left--;
            m_ovf = 0;
            if (v) begin
                if (m_pend == PendMax) begin
                    m_ovf = 1;
                    m_ovfs++;
                end else begin
                    m_pend++;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("led", {31'd0, led_o}, (m_left > int'(OffC)) ? 32'd1 : 32'd0);
        chk("busy", {31'd0, busy_o}, (m_left > 0) ? 32'd1 : 32'd0);
        chk("pending", {29'd0, pending_o}, 32'(m_pend));
        chk("overflow", {31'd0, overflow_o}, {31'd0, m_ovf});
    endtask

    task automatic step(input bit v);
        @(negedge clk_i);
        ev_i = v;
        @(posedge clk_i);
        model_edge(v);
        #1;
        stepn++;
        check_outputs();
        if (led_o === 1'b1 && prev_led === 1'b0) dut_blinks++;
        prev_led = led_o;
        if (overflow_o === 1'b1) dut_ovfs++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic check_totals(input string tag);
        chk({tag, "_blinks"}, 32'(dut_blinks), 32'(m_blinks));
        chk({tag, "_ovfs"}, 32'(dut_ovfs), 32'(m_ovfs));
    endtask

    // Assert reset asynchronously between edges while a blink is in its on phase.
    task automatic reset_mid_on();
        #1;
        rst_i = 1'b1;
        #1;
        chk("rst_led", {31'd0, led_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_pending", {29'd0, pending_o}, 32'd0);
        chk("rst_overflow", {31'd0, overflow_o}, 32'd0);
        m_pend   = 0;
        m_left   = 0;
        m_ovf    = 0;
        prev_led = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        ev_i  = 1'b0;
        #12;
        check_outputs();
        @(negedge clk_i);
        rst_i = 1'b0;
        idle(2);

        // Single event: 4 on, 3 off, then idle
        step(1'b1);
        chk("single_led_start", {31'd0, led_o}, 32'd1);
        idle(3);
        chk("single_led_last_on", {31'd0, led_o}, 32'd1);
        step(1'b0);
        chk("single_led_gap", {31'd0, led_o}, 32'd0);
        idle(2);
        chk("single_busy_last_gap", {31'd0, busy_o}, 32'd1);
        step(1'b0);
        chk("single_busy_done", {31'd0, busy_o}, 32'd0);
        idle(3);
        check_totals("single");

        // Queue: events at k, k+2, k+6
        step(1'b1); step(1'b0); step(1'b1);
        chk("queue_pend1", {29'd0, pending_o}, 32'd1);
        idle(3);
        step(1'b1);
        chk("queue_pend2", {29'd0, pending_o}, 32'd2);
        idle(25);
        check_totals("queue");

        // Simultaneous: event on last gap cycle with one queued
        step(1'b1); step(1'b0); step(1'b1);
        idle(4);
        step(1'b1);
        chk("simul_pend", {29'd0, pending_o}, 32'd1);
        chk("simul_led", {31'd0, led_o}, 32'd1);
        idle(20);
        check_totals("simul");

        // Overflow: long burst saturates the queue
        for (int i = 0; i < 12; i++) step(1'b1);
        chk("ovf_pend_sat", {29'd0, pending_o}, 32'd7);
        idle(70);
        chk("ovf_drained", {31'd0, busy_o}, 32'd0);
        check_totals("ovf");

        // Level event held three cycles from idle
        step(1'b1); step(1'b1); step(1'b1);
        chk("level_peak", {29'd0, pending_o}, 32'd2);
        idle(25);
        check_totals("level");

        // Async reset in on phase with queued work; nothing resumes afterwards
        step(1'b1); step(1'b1); step(1'b0);
        reset_mid_on();
        idle(12);

        // Random stream with periodic mid-blink resets
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 120; i++) step($urandom_range(0, 2) == 0);
            if (m_left > int'(OffC)) reset_mid_on();
        end
        idle(70);
        check_totals("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
